// File: rtl/line_fetch_if.sv
// Scheduler-facing handshake bundle: line-done pulses in, bank selects, run/fetch gating and status out.
// master = scheduler side, slave = capture/output datapath side.
interface line_fetch_if #(
  parameter int CNT_W = 16
) ();
  logic             in_sof;
  logic             in_eol;
  logic             out_eol;
  logic             fetch_en;
  logic             wr_bank;
  logic             rd_bank;
  logic             out_run;
  logic [CNT_W-1:0] in_y;
  logic [CNT_W-1:0] out_y;
  logic             underflow;
  logic             desync;
  logic [CNT_W-1:0] err_count;
  logic [1:0]       sched_state;

  modport master (
    input  in_sof, in_eol, out_eol,
    output fetch_en, wr_bank, rd_bank, out_run, in_y, out_y,
           underflow, desync, err_count, sched_state
  );

  modport slave (
    output in_sof, in_eol, out_eol,
    input  fetch_en, wr_bank, rd_bank, out_run, in_y, out_y,
           underflow, desync, err_count, sched_state
  );
endinterface

// File: rtl/line_fetch_scheduler.sv
// Ping-pong line buffer scheduler: bank selects, line counters, frame sync, underflow/desync recovery.
// fetch_en is a decode of registered state; all other outputs register one cycle after their cause.
module line_fetch_scheduler #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int CNT_W  = 16
) (
  input  logic         m_axis_vid_aclk,
  input  logic         aresetn,
  line_fetch_if.master lf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_Y = CNT_W'(HEIGHT - 1);

  state_t           state, state_n;
  logic [1:0]       full, full_n;
  logic             wr_bank, wr_bank_n;
  logic             rd_bank, rd_bank_n;
  logic [CNT_W-1:0] in_y, in_y_n;
  logic [CNT_W-1:0] out_y, out_y_n;
  logic             sof_wait, sof_wait_n;
  logic             underflow, underflow_n;
  logic             desync, desync_n;
  logic [CNT_W-1:0] err_count, err_count_n;

  logic             fetch_en;
  logic             in_acc;
  logic             next_ready;
  logic             uf_evt;
  logic             ds_evt;
  logic [1:0]       err_inc;
  logic [CNT_W:0]   err_sum;

  always_ff @(posedge m_axis_vid_aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= S_IDLE;
      full      <= 2'b00;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      in_y      <= '0;
      out_y     <= '0;
      sof_wait  <= 1'b0;
      underflow <= 1'b0;
      desync    <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      full      <= full_n;
      wr_bank   <= wr_bank_n;
      rd_bank   <= rd_bank_n;
      in_y      <= in_y_n;
      out_y     <= out_y_n;
      sof_wait  <= sof_wait_n;
      underflow <= underflow_n;
      desync    <= desync_n;
      err_count <= err_count_n;
    end
  end

  always_comb begin
    state_n     = state;
    full_n      = full;
    wr_bank_n   = wr_bank;
    rd_bank_n   = rd_bank;
    in_y_n      = in_y;
    out_y_n     = out_y;
    sof_wait_n  = sof_wait;
    fetch_en    = 1'b0;
    in_acc      = 1'b0;
    next_ready  = 1'b0;
    uf_evt      = 1'b0;
    ds_evt      = 1'b0;

    case (state)
      S_IDLE: begin
        full_n     = 2'b00;
        wr_bank_n  = 1'b0;
        rd_bank_n  = 1'b0;
        in_y_n     = '0;
        out_y_n    = '0;
        sof_wait_n = 1'b0;
        if (lf.in_sof) begin
          state_n = S_PRIME;
        end
      end

      S_PRIME: begin
        fetch_en = 1'b1;
        if (lf.in_eol) begin
          full_n    = 2'b01;
          wr_bank_n = 1'b1;
          in_y_n    = CNT_W'(1);
          rd_bank_n = 1'b0;
          out_y_n   = '0;
          state_n   = S_RUN;
        end
      end

      S_RUN: begin
        fetch_en = ~full[wr_bank] & ~sof_wait;
        in_acc   = lf.in_eol & fetch_en;

        if (in_acc) begin
          full_n[wr_bank] = 1'b1;
          wr_bank_n       = ~wr_bank;
          if (in_y == LAST_Y) begin
            in_y_n     = '0;
            sof_wait_n = 1'b1;
          end else begin
            in_y_n = in_y + CNT_W'(1);
          end
        end

        // in_y==0 with no pending wait is the accepted SOF beat itself
        if (lf.in_sof) begin
          if (sof_wait) begin
            sof_wait_n = 1'b0;
          end else if (in_y != '0) begin
            ds_evt = 1'b1;
          end
        end

        if (lf.out_eol) begin
          // a line finishing in this same cycle into the next bank counts as present
          next_ready = full[~rd_bank] | (in_acc & (wr_bank == ~rd_bank));
          uf_evt     = ~next_ready;
          full_n[rd_bank] = 1'b0;
          rd_bank_n       = ~rd_bank;
          out_y_n         = (out_y == LAST_Y) ? '0 : out_y + CNT_W'(1);
        end

        if (uf_evt | ds_evt) begin
          state_n    = S_IDLE;
          full_n     = 2'b00;
          wr_bank_n  = 1'b0;
          rd_bank_n  = 1'b0;
          in_y_n     = '0;
          out_y_n    = '0;
          sof_wait_n = 1'b0;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    underflow_n = underflow | uf_evt;
    desync_n    = desync | ds_evt;
    err_inc     = {1'b0, uf_evt} + {1'b0, ds_evt};
    err_sum     = {1'b0, err_count} + (CNT_W + 1)'(err_inc);
    err_count_n = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
  end

  assign lf.fetch_en    = fetch_en;
  assign lf.wr_bank     = wr_bank;
  assign lf.rd_bank     = rd_bank;
  assign lf.out_run     = (state == S_RUN);
  assign lf.in_y        = in_y;
  assign lf.out_y       = out_y;
  assign lf.underflow   = underflow;
  assign lf.desync      = desync;
  assign lf.err_count   = err_count;
  assign lf.sched_state = state;

endmodule
